// File: rtl/find_nearest_weighted.sv
// rtl/find_nearest_weighted.sv - weighted nearest-neighbour scan over a 2-D codebook ROM
// Optional macro FNW_SAT_EN: saturate multiply/add magnitudes instead of wrapping.
module find_nearest_weighted #(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int ENTRIES = 256,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_fnw,
  input  logic [N-1:0]  x0,
  input  logic [N-1:0]  x1,
  input  logic [N-1:0]  w0,
  input  logic [N-1:0]  w1,
  output logic [AW-1:0] cb_addr,
  input  logic [N-1:0]  cb0,
  input  logic [N-1:0]  cb1,
  output logic [AW-1:0] best_index,
  output logic [N-1:0]  best_e,
  output logic          done_fnw
);

  localparam int M = N - 1;
  localparam logic [M-1:0] MAG_MAX = '1;
`ifdef FNW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADDR, S_DIFF, S_ERR, S_CMP, S_DONE} state_t;

  // Results with zero magnitude always carry a positive sign, so -0 never leaks out.
  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*M-1:0] p;
    logic [2*M-1:0] s;
    logic [M-1:0]   m;
    p = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
    s = p >> Q;
    m = (SAT && (|s[2*M-1:M])) ? MAG_MAX : s[M-1:0];
    return {(a[M] ^ b[M]) & (|m), m};
  endfunction

  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [M:0]   sum;
    logic [M-1:0] m;
    logic         sg;
    sum = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
    if (a[M] == b[M]) begin
      m  = (SAT && sum[M]) ? MAG_MAX : sum[M-1:0];
      sg = a[M];
    end else if (a[M-1:0] >= b[M-1:0]) begin
      m  = a[M-1:0] - b[M-1:0];
      sg = a[M];
    end else begin
      m  = b[M-1:0] - a[M-1:0];
      sg = b[M];
    end
    return {sg & (|m), m};
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [N-1:0]  x0_q, x0_d, x1_q, x1_d, w0_q, w0_d, w1_q, w1_d;
  logic [N-1:0]  d0_q, d0_d, d1_q, d1_d;
  logic [M-1:0]  e_q, e_d;
  logic [AW-1:0] best_index_q, best_index_d;
  logic [N-1:0]  best_e_q, best_e_d;
  logic          done_q, done_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    w0_d         = w0_q;
    w1_d         = w1_q;
    d0_d         = d0_q;
    d1_d         = d1_q;
    e_d          = e_q;
    best_index_d = best_index_q;
    best_e_d     = best_e_q;
    done_d       = done_q;
    case (state_q)
      S_IDLE: if (start_fnw) state_d = S_LOAD;
      S_LOAD: begin
        x0_d         = x0;
        x1_d         = x1;
        w0_d         = w0;
        w1_d         = w1;
        idx_d        = '0;
        best_e_d     = {1'b0, MAG_MAX};
        best_index_d = '0;
        done_d       = 1'b0;
        state_d      = S_ADDR;
      end
      S_ADDR: state_d = S_DIFF;
      S_DIFF: begin
        d0_d    = sm_add(x0_q, {~cb0[M], cb0[M-1:0]});
        d1_d    = sm_add(x1_q, {~cb1[M], cb1[M-1:0]});
        state_d = S_ERR;
      end
      S_ERR: begin
        e_d = M'(sm_add(sm_mul(w0_q, sm_mul(d0_q, d0_q)),
                        sm_mul(w1_q, sm_mul(d1_q, d1_q))));
        state_d = S_CMP;
      end
      S_CMP: begin
        // Strict less-than keeps the lowest index on ties.
        if (e_q < best_e_q[M-1:0]) begin
          best_e_d     = {1'b0, e_q};
          best_index_d = idx_q;
        end
        if (idx_q == AW'(ENTRIES - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_ADDR;
        end
      end
      S_DONE: if (!start_fnw) begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      d0_q         <= '0;
      d1_q         <= '0;
      e_q          <= '0;
      best_index_q <= '0;
      best_e_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      e_q          <= e_d;
      best_index_q <= best_index_d;
      best_e_q     <= best_e_d;
      done_q       <= done_d;
    end
  end

  assign cb_addr    = idx_q;
  assign best_index = best_index_q;
  assign best_e     = best_e_q;
  assign done_fnw   = done_q;

endmodule
